mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-wide program/data memory between three requesters: host loader (port h), instruction fetch (port f), and LD/ST data path (port d).
- Fetch is a 2-byte little-endian read: low byte at addr, high byte at addr+1. Host and data transfers are single-byte reads or writes.
- Sits between the core's FETCH/EXECUTE sequencing and a synchronous 1-cycle-latency memory, replacing direct memory indexing.

Parameters:
ADDR_W, 16, address width (WIDTH_DOUBLE)
DATA_W, 8, memory byte width (WIDTH_WORD)

Ports:
clk      in   1         clock, all state changes on posedge
rst_n    in   1         reset, asynchronous, active-low
h_req    in   1         host request, held until h_ack
h_we     in   1         host write (1) / read (0)
h_addr   in   ADDR_W    host address
h_wdata  in   DATA_W    host write byte
h_ack    out  1         host completion pulse
h_rdata  out  DATA_W    host read byte
f_req    in   1         fetch request
f_addr   in   ADDR_W    fetch address (low byte)
f_ack    out  1         fetch completion pulse
f_rdata  out  2*DATA_W  fetched op, {mem[addr+1], mem[addr]}
d_req    in   1         data request
d_we     in   1         data write / read
d_addr   in   ADDR_W    data address
d_wdata  in   DATA_W    data write byte
d_ack    out  1         data completion pulse
d_rdata  out  DATA_W    data read byte
mem_en    out  1        memory access strobe
mem_we    out  1        memory write
mem_addr  out  ADDR_W   memory address
mem_wdata out  DATA_W   memory write byte
mem_rdata in   DATA_W   valid the cycle after a mem_en read

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all acks, mem_en, mem_we = 0; mem_addr, mem_wdata, all rdata = 0; rr pointer = "data served last".
- State machine, states IDLE, LO, HI, CAP, RESP:
  - IDLE: samples requests and picks a winner. Latches winner id, we, addr, wdata. Next state LO. With no request, stays in IDLE.
  - LO: mem_en=1, mem_addr=latched addr, mem_we=latched we.
    - Write: next state RESP.
    - Fetch: next state HI.
    - Byte read: next state CAP.
  - HI (fetch only): mem_en=1, mem_addr=addr+1 mod 2^ADDR_W (0xFFFF wraps to 0x0000). Captures mem_rdata into f_rdata[7:0]. Next state CAP.
  - CAP: captures mem_rdata into the winner's rdata; for fetch, into f_rdata[15:8]. Next state RESP.
  - RESP: winner's ack=1 for exactly this cycle; requests are not sampled. Next state IDLE.
- mem_en and mem_we are 0 in IDLE, CAP and RESP. mem_we is never 1 for fetch.
- Latency from the IDLE cycle that samples req (cycle N) to ack high:
  - write: N+2
  - byte read: N+3
  - fetch: N+4
  - Back-to-back throughput: one access per latency+1 cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until its ack.
  - Requester drops req on the edge ending the ack cycle.
  - req high in any IDLE cycle is a new request.
  - rdata holds its value until overwritten by that port's next read.
- Arbitration in IDLE:
  - h_req has absolute priority.
  - Otherwise round-robin between d and f: on a tie, the one not served last wins.
  - A lone requester wins regardless of the pointer.
  - The pointer updates only on d/f grants; host grants leave it unchanged.
  - A request arriving mid-transfer waits; no preemption.
- Reset mid-transfer: the transfer is aborted. No ack is issued, mem_en drops immediately (async), and the FSM returns to IDLE.
- Request changed mid-transfer: latched values are used; the change is ignored.

Decomposition:
- const.v gains ARB_IDLE, ARB_LO, ARB_HI, ARB_CAP, ARB_RESP (3-bit) and requester ids ARB_ID_H, ARB_ID_F, ARB_ID_D (2-bit), alongside the existing STATE_*/OP_* constants.
- One combinational sub-module, arb_pick: inputs h_req, f_req, d_req, rr pointer; outputs one-hot grant.

Test Plan:
- Byte read: mem[0x0010]=0xA5; d_req read 0x0010 -> d_ack at N+3, d_rdata=0xA5; mem_en high only in cycle N+1.
- Fetch: mem[8]=0x18, mem[9]=0x71; f_req addr 8 -> mem_addr 8 then 9; f_ack at N+4, f_rdata=0x7118.
- Fetch wrap: mem[0xFFFF]=0x34, mem[0]=0x12; f_addr 0xFFFF -> second access at 0x0000, f_rdata=0x1234.
- Priority and round-robin: h, f, d all requesting from reset -> grant order h, f, d. Then f and d re-requesting -> order f, d, f, d. Host raised mid-fetch waits until RESP, then wins the next IDLE.
- Write: h_req we=1 addr 0x0100 wdata 0x5C -> mem_we=1 at N+1, h_ack at N+2. Follow-up d read of 0x0100 returns 0x5C.
- Reset mid-fetch: rst_n low in HI state -> mem_en=0 immediately, no f_ack, state IDLE. A reissued fetch after rst_n high completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and grant bit positions.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_LO   = 3'd1,
    ARB_HI   = 3'd2,
    ARB_CAP  = 3'd3,
    ARB_RESP = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_ID_H = 2'd0,
    ARB_ID_F = 2'd1,
    ARB_ID_D = 2'd2
  } arb_id_t;

  localparam int unsigned GNT_H = 0;
  localparam int unsigned GNT_F = 1;
  localparam int unsigned GNT_D = 2;

  function automatic arb_id_t gnt_to_id(input logic [2:0] gnt);
    if (gnt[GNT_H])      return ARB_ID_H;
    else if (gnt[GNT_F]) return ARB_ID_F;
    else                 return ARB_ID_D;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection: host has absolute priority, fetch/data alternate on a tie.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_h_req,
  input  logic       i_f_req,
  input  logic       i_d_req,
  input  logic       i_last_d,
  output logic [2:0] o_gnt
);

  // i_last_d=1 means data took the previous f/d grant, so fetch wins a tie
  always_comb begin
    o_gnt = '0;
    if (i_h_req)                              o_gnt[GNT_H] = 1'b1;
    else if (i_f_req && (!i_d_req || i_last_d)) o_gnt[GNT_F] = 1'b1;
    else if (i_d_req)                         o_gnt[GNT_D] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous memory between host, instruction fetch (2-byte LE) and data ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                h_req,
  input  logic                h_we,
  input  logic [ADDR_W-1:0]   h_addr,
  input  logic [DATA_W-1:0]   h_wdata,
  output logic                h_ack,
  output logic [DATA_W-1:0]   h_rdata,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_ack,
  output logic [2*DATA_W-1:0] f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t          r_state, w_next;
  arb_id_t             r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_last_d;
  logic [DATA_W-1:0]   r_h_rdata, r_d_rdata;
  logic [2*DATA_W-1:0] r_f_rdata;
  logic [2:0]          w_gnt;

  arb_pick u_pick (
    .i_h_req  (h_req),
    .i_f_req  (f_req),
    .i_d_req  (d_req),
    .i_last_d (r_last_d),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_id      <= ARB_ID_H;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_last_d  <= 1'b1;
      r_h_rdata <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB_IDLE && |w_gnt) begin
        r_id    <= gnt_to_id(w_gnt);
        r_we    <= w_gnt[GNT_H] ? h_we : (w_gnt[GNT_D] ? d_we : 1'b0);
        r_addr  <= w_gnt[GNT_H] ? h_addr : (w_gnt[GNT_D] ? d_addr : f_addr);
        r_wdata <= w_gnt[GNT_H] ? h_wdata : d_wdata;
        if (!w_gnt[GNT_H]) r_last_d <= w_gnt[GNT_D];
      end
      if (r_state == ARB_HI) r_f_rdata[DATA_W-1:0] <= mem_rdata;
      if (r_state == ARB_CAP) begin
        case (r_id)
          ARB_ID_H: r_h_rdata <= mem_rdata;
          ARB_ID_F: r_f_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
          default:  r_d_rdata <= mem_rdata;
        endcase
      end
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    h_ack     = 1'b0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    case (r_state)
      ARB_IDLE: if (|w_gnt) w_next = ARB_LO;
      ARB_LO: begin
        mem_en   = 1'b1;
        mem_we   = r_we;
        mem_addr = r_addr;
        if (r_we) mem_wdata = r_wdata;
        if (r_we)                  w_next = ARB_RESP;
        else if (r_id == ARB_ID_F) w_next = ARB_HI;
        else                       w_next = ARB_CAP;
      end
      ARB_HI: begin
        mem_en   = 1'b1;
        mem_addr = r_addr + ADDR_W'(1);
        w_next   = ARB_CAP;
      end
      ARB_CAP: w_next = ARB_RESP;
      ARB_RESP: begin
        h_ack  = (r_id == ARB_ID_H);
        f_ack  = (r_id == ARB_ID_F);
        d_ack  = (r_id == ARB_ID_D);
        w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign h_rdata = r_h_rdata;
  assign f_rdata = r_f_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-level schedule model of the arbiter plus a 1-cycle-latency RAM.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        h_req, h_we, h_ack;
  logic [15:0] h_addr;
  logic [7:0]  h_wdata, h_rdata;
  logic        f_req, f_ack;
  logic [15:0] f_addr, f_rdata;
  logic        d_req, d_we, d_ack;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // RAM: unwritten locations read as init_byte(addr)
  logic [7:0]  ram [logic [15:0]];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] = pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_byte(mem_addr);
    end
  end

  // ---------------- model ----------------
  typedef struct {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [2:0]  ack;
    logic        rdv;
    logic [15:0] rd;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm [logic [15:0]];
  logic [15:0] exp_rd [3];
  int          last_df = 2;
  int          tests = 0, fails = 0;
  int          ack_log[$];
  logic [15:0] en_log[$];
  logic [2:0]  acked_v = '0;

  logic [2:0]  act, dwe;
  logic [15:0] dad [3];
  logic [7:0]  dwd [3];
  logic        rnd_mode = 1'b0;

  function automatic logic [7:0] mm_rd(input logic [15:0] a);
    return mm.exists(a) ? mm[a] : init_byte(a);
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.en = 1'b0; e.we = 1'b0; e.addr = '0; e.wd = '0; e.ack = '0; e.rdv = 1'b0; e.rd = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic pick();
    int w;
    logic we;
    logic [15:0] a;
    logic [7:0] wd;
    exp_t e;
    if (h_req) w = 0;
    else if (f_req && d_req) w = (last_df == 2) ? 1 : 2;
    else if (f_req) w = 1;
    else w = 2;
    if (w != 0) last_df = w;
    we = (w == 0) ? h_we : ((w == 2) ? d_we : 1'b0);
    a  = (w == 0) ? h_addr : ((w == 2) ? d_addr : f_addr);
    wd = (w == 0) ? h_wdata : d_wdata;
    e = blank(); e.en = 1'b1; e.we = we; e.addr = a; e.wd = wd;
    q.push_back(e);
    if (we) begin
      mm[a] = wd;
    end else if (w == 1) begin
      e = blank(); e.en = 1'b1; e.addr = a + 16'd1;
      q.push_back(e);
      q.push_back(blank());
    end else begin
      q.push_back(blank());
    end
    e = blank(); e.ack = 3'(1 << w);
    if (!we) begin
      e.rdv = 1'b1;
      e.rd  = (w == 1) ? {mm_rd(a + 16'd1), mm_rd(a)} : {8'h00, mm_rd(a)};
    end
    q.push_back(e);
  endtask

  task automatic model_check();
    exp_t e;
    logic [2:0] a;
    logic [15:0] got, exp;
    a = {d_ack, f_ack, h_ack};
    if (!rst_n) begin
      q.delete();
      last_df = 2;
      for (int p = 0; p < 3; p++) exp_rd[p] = '0;
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_acks", 32'(a), 32'(0));
      chk("rst_rdata", 32'({h_rdata, f_rdata, d_rdata}), 32'(0));
      acked_v = '0;
      return;
    end
    if (q.size() == 0) begin
      e = blank();
      chk("hold_h_rdata", 32'(h_rdata), 32'(exp_rd[0]));
      chk("hold_f_rdata", 32'(f_rdata), 32'(exp_rd[1]));
      chk("hold_d_rdata", 32'(d_rdata), 32'(exp_rd[2]));
      if (h_req || f_req || d_req) pick();
    end else begin
      e = q.pop_front();
    end
    chk("mem_en", 32'(mem_en), 32'(e.en));
    chk("mem_we", 32'(mem_we), 32'(e.we));
    if (e.en) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
    if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
    chk("acks", 32'(a), 32'(e.ack));
    for (int p = 0; p < 3; p++) begin
      if (e.ack[p]) begin
        got = (p == 0) ? {8'h00, h_rdata} : ((p == 1) ? f_rdata : {8'h00, d_rdata});
        exp = e.rdv ? e.rd : exp_rd[p];
        chk("ack_rdata", 32'(got), 32'(exp));
        exp_rd[p] = exp;
      end
      if (a[p]) ack_log.push_back(p);
    end
    if (mem_en) en_log.push_back(mem_addr);
    acked_v = a;
  endtask

  // ---------------- drivers ----------------
  task automatic apply();
    h_req = act[0]; h_we = dwe[0]; h_addr = dad[0]; h_wdata = dwd[0];
    f_req = act[1]; f_addr = dad[1];
    d_req = act[2]; d_we = dwe[2]; d_addr = dad[2]; d_wdata = dwd[2];
  endtask

  task automatic rand_issue();
    int r;
    for (int p = 0; p < 3; p++) begin
      if (!act[p] && !acked_v[p] && $urandom_range(0, 3) == 0) begin
        act[p] = 1'b1;
        dwe[p] = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        dad[p] = (r == 0) ? 16'hFFFF : ((r == 1) ? 16'hFFFE : 16'($urandom_range(0, 31)));
        dwd[p] = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) if (acked_v[p]) act[p] = 1'b0;
    if (rnd_mode) rand_issue();
    apply();
  endtask

  task automatic do_xfer(input int p, input logic we, input logic [15:0] ad,
                         input logic [7:0] wd, output int lat);
    act[p] = 1'b1; dwe[p] = we; dad[p] = ad; dwd[p] = wd;
    apply();
    en_log.delete();
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acked_v[p]) begin
        lat = n;
        break;
      end
    end
    chk("xfer_acked", 32'(acked_v[p]), 32'(1));
  endtask

  task automatic run_quiet(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (act == 3'b000 && q.size() == 0) break;
      tick();
    end
    chk("quiet", 32'(act), 32'(0));
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; mm[a] = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic chk_order(input string nm, input int exp[$]);
    chk({nm, "_len"}, 32'(ack_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < ack_log.size(); i++)
      chk(nm, 32'(ack_log[i]), 32'(exp[i]));
  endtask

  // ---------------- sequence ----------------
  initial begin
    int lat;
    int ord[$];
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    act = '0; dwe = '0;
    for (int p = 0; p < 3; p++) begin dad[p] = '0; dwd[p] = '0; exp_rd[p] = '0; end
    apply();
    @(posedge clk); #1;
    preload(16'h0010, 8'hA5);
    preload(16'h0008, 8'h18);
    preload(16'h0009, 8'h71);
    preload(16'hFFFF, 8'h34);
    preload(16'h0000, 8'h12);

    chk("reset_mem_en", 32'(mem_en), 32'(0));
    chk("reset_mem_we", 32'(mem_we), 32'(0));
    chk("reset_mem_addr", 32'(mem_addr), 32'(0));
    chk("reset_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("reset_acks", 32'({h_ack, f_ack, d_ack}), 32'(0));
    chk("reset_rdata", 32'({h_rdata, f_rdata, d_rdata}), 32'(0));
    rst_n = 1'b1;
    tick(); tick();

    do_xfer(2, 1'b0, 16'h0010, 8'h00, lat);
    chk("rd_latency", 32'(lat), 32'(3));
    chk("rd_data", 32'(d_rdata), 32'(8'hA5));
    chk("rd_en_cycles", 32'(en_log.size()), 32'(1));

    do_xfer(1, 1'b0, 16'h0008, 8'h00, lat);
    chk("fetch_latency", 32'(lat), 32'(4));
    chk("fetch_data", 32'(f_rdata), 32'(16'h7118));
    chk("fetch_en_cycles", 32'(en_log.size()), 32'(2));
    chk("fetch_addr_lo", 32'(en_log[0]), 32'(16'h0008));
    chk("fetch_addr_hi", 32'(en_log[1]), 32'(16'h0009));

    do_xfer(1, 1'b0, 16'hFFFF, 8'h00, lat);
    chk("wrap_data", 32'(f_rdata), 32'(16'h1234));
    chk("wrap_addr_hi", 32'(en_log[1]), 32'(16'h0000));

    do_xfer(0, 1'b1, 16'h0100, 8'h5C, lat);
    chk("wr_latency", 32'(lat), 32'(2));
    chk("wr_en_cycles", 32'(en_log.size()), 32'(1));
    do_xfer(2, 1'b0, 16'h0100, 8'h00, lat);
    chk("wr_readback", 32'(d_rdata), 32'(8'h5C));

    // priority from idle: h, then f (data served last), then d
    ack_log.delete();
    act = 3'b111; dwe = 3'b100;
    dad[0] = 16'h0030; dad[1] = 16'h0032; dad[2] = 16'h0031; dwd[2] = 8'h3C;
    apply();
    run_quiet(60);
    ord = '{0, 1, 2};
    chk_order("prio_order", ord);

    ack_log.delete();
    for (int r = 0; r < 2; r++) begin
      act = 3'b110; dwe = 3'b000; dad[1] = 16'h0004; dad[2] = 16'h0005;
      apply();
      run_quiet(60);
    end
    ord = '{1, 2, 1, 2};
    chk_order("rr_order", ord);

    // host and data raised while a fetch is in flight
    ack_log.delete();
    act = 3'b010; dad[1] = 16'h0008;
    apply();
    tick(); tick();
    act = 3'b101; dwe = 3'b000; dad[0] = 16'h0020; dad[2] = 16'h0021;
    apply();
    run_quiet(60);
    ord = '{1, 0, 2};
    chk_order("midfetch_order", ord);

    // reset asserted while the fetch is in its HI cycle
    act = 3'b010; dad[1] = 16'h0008;
    apply();
    tick(); tick();
    chk("hi_mem_en", 32'(mem_en), 32'(1));
    chk("hi_mem_addr", 32'(mem_addr), 32'(16'h0009));
    rst_n = 1'b0;
    #1;
    chk("async_mem_en", 32'(mem_en), 32'(0));
    chk("async_f_ack", 32'(f_ack), 32'(0));
    act = '0;
    apply();
    ack_log.delete();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("no_ack_after_rst", 32'(ack_log.size()), 32'(0));
    do_xfer(1, 1'b0, 16'h0008, 8'h00, lat);
    chk("refetch_latency", 32'(lat), 32'(4));
    chk("refetch_data", 32'(f_rdata), 32'(16'h7118));

    rnd_mode = 1'b1;
    repeat (3000) tick();
    rnd_mode = 1'b0;
    run_quiet(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
